sha3_seq_ctrl: RTL and testbench
================================

Name: sha3_seq_ctrl

Overview:
- Sequencer for the SHA3-256 sponge datapath; the datapath's strobes (sample, answer, keccak_sp, keccak_clk) and its controls rst2, finish and sel all come from this block, driven by a single system clock.
- Accepts one 1088-bit rate block per valid/ready handshake and tags it last/not-last.
- Per block: strobes padding capture, absorbs the block, runs NR two-phase Keccak rounds, then commits the permutation result.
- Signals message completion to the NTRU-HRSS KEM top level (random-key vs shared-key hashing).

Parameters:
- NR, 24, Keccak-f rounds per permutation.
- GAP, 0, idle settle cycles inserted after every strobe; legal 0..7.
- CNT_W, 8, width of the absorbed-block counter.

Ports:
- clk  in  1  system clock.
- rst1  in  1  reset.
- blk_valid  in  1  rate block presented on the datapath prm bus.
- blk_last  in  1  block is the final block of the message; sampled on accept.
- blk_mode  in  1  1 = random-key hash, 0 = shared-key hash; sampled on the first block only.
- blk_ready  out  1  controller can accept a block.
- abort  in  1  synchronous abort of the current message.
- sample_o  out  1  one-cycle strobe; captures the padded block.
- ksp_o  out  1  one-cycle strobe; Keccak state update.
- kclk_o  out  1  one-cycle strobe; Keccak pipeline register.
- answer_o  out  1  one-cycle strobe; commits the permutation output.
- rst2_o  out  1  Keccak load/round-constant reset level.
- finish_o  out  1  padding select for the final block.
- sel_o  out  1  pad selector held for the whole message.
- clr_o  out  1  one-cycle clear of the sponge output register (ORed into the datapath rst1).
- busy  out  1  message in progress.
- done  out  1  one-cycle pulse: digest valid.
- rnd  out  5  current round index.
- blk_cnt  out  CNT_W  blocks absorbed in the current message.

Behaviour:
- Reset rst1 is asynchronous, active-high; clock is clk (rising edge). All outputs are registered.
- Reset values: rst2_o=1; blk_ready=1; every other output 0. FSM resets to IDLE with in_msg=0.
- FSM states: IDLE, SAMPLE, LOAD, RND_A, RND_B, ANSWER, DONE.
- Each non-IDLE state lasts 1+GAP cycles. Its strobe is high only in the first of those cycles; a GAP counter times the remainder.
- IDLE:
  - blk_ready=1.
  - Accept when blk_valid & blk_ready & ~abort at edge T. On accept, latch blk_last into finish_o.
  - If in_msg=0: latch blk_mode into sel_o, set in_msg, clear blk_cnt.
  - Next state SAMPLE.
- SAMPLE: sample_o=1 in its first cycle (cycle T+1). clr_o=1 in the same cycle if this is the message's first block. rst2_o=1.
- LOAD: ksp_o=1 with rst2_o=1 (absorb, rc init); rnd=0.
- RND_A: kclk_o=1, rst2_o=0.
- RND_B: ksp_o=1, rst2_o=0. At state exit:
  - if rnd==NR-1, go to ANSWER;
  - else rnd+1 and go to RND_A.
- ANSWER: answer_o=1, then increment blk_cnt, which saturates at all-ones.
  - If finish_o: go to DONE.
  - Else: go to IDLE with in_msg kept, sel_o held.
- DONE: done=1 in its first cycle. Then clear in_msg, finish_o and rnd; go to IDLE. blk_cnt holds until the next first-block accept.
- rst2_o is 1 in IDLE, SAMPLE and LOAD; 0 in RND_A, RND_B, ANSWER and DONE. It is stable across every ksp_o strobe.
- busy = in_msg or state != IDLE.
- Strobes are mutually exclusive; at most one of sample_o/ksp_o/kclk_o/answer_o is high per cycle.
- Timing, strobe index k = 0..2NR+2:
  - strobe k fires at cycle T+1+k(1+GAP);
  - answer_o fires at T+1+(2NR+2)(1+GAP), i.e. T+51 for GAP=0, NR=24;
  - done fires at T+1+(2NR+3)(1+GAP), i.e. T+52.
- blk_ready=0 from accept until the next IDLE. Back-to-back blocks: the next accept is possible one cycle after the ANSWER/DONE phase ends.
- blk_mode on non-first blocks is ignored; sel_o never changes mid-message.
- abort: takes effect at the next edge in any state.
  - State goes to IDLE; all strobes 0; rst2_o=1; clr_o pulses 1 cycle.
  - in_msg, finish_o, rnd and blk_cnt clear; no done.
  - abort together with blk_valid in IDLE: abort wins, no accept.
- rst1 mid-round: immediate return to reset values; no strobe glitches on deassertion.

Test Plan:
- GAP=0, single block with blk_last=1, blk_mode=1, accepted at T:
  - sample_o at T+1, clr_o at T+1, LOAD ksp_o with rst2_o=1 at T+2;
  - 24 kclk_o/ksp_o pairs at T+3..T+50;
  - answer_o at T+51, done at T+52; sel_o=1, blk_cnt=1; busy falls at T+53.
- GAP=1, same stimulus: strobes every 2 cycles; answer_o at T+101, done at T+103; no two strobes adjacent.
- Two-block message: block A last=0 mode=0, block B last=1 mode=1.
  - Between blocks: no done, busy stays 1, clr_o only at A's sample, sel_o stays 0.
  - blk_cnt=2 at done; LOAD rst2_o=1 precedes each absorption.
- abort asserted at RND_B with rnd=10: next cycle IDLE, clr_o=1 one cycle, rnd=0, no answer_o/done, blk_ready=1.
- abort and blk_valid together in IDLE: no sample_o; blk_ready stays 1.
- rst1 pulsed at round 5: all outputs at reset values asynchronously. After release, a fresh block completes normally with the GAP=0 timing above.

Source files
------------

// File: rtl/sha3_seq_ctrl_if.sv
// Rate-block handshake between the KEM-side block source and the sponge sequencer.
interface sha3_seq_ctrl_if;
    logic blk_valid;
    logic blk_last;
    logic blk_mode;
    logic blk_ready;

    modport master (
        output blk_valid,
        output blk_last,
        output blk_mode,
        input  blk_ready
    );

    modport slave (
        input  blk_valid,
        input  blk_last,
        input  blk_mode,
        output blk_ready
    );
endinterface

// File: rtl/sha3_seq_ctrl.sv
// SHA3-256 sponge sequencer: per rate block it strobes padding capture,
// absorption, NR two-phase Keccak rounds and the result commit, and flags
// digest completion to the KEM top level.
module sha3_seq_ctrl #(
    parameter int unsigned NR    = 24,
    parameter int unsigned GAP   = 0,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst1,
    sha3_seq_ctrl_if.slave   blk,
    input  logic             abort,
    output logic             sample_o,
    output logic             ksp_o,
    output logic             kclk_o,
    output logic             answer_o,
    output logic             rst2_o,
    output logic             finish_o,
    output logic             sel_o,
    output logic             clr_o,
    output logic             busy,
    output logic             done,
    output logic [4:0]       rnd,
    output logic [CNT_W-1:0] blk_cnt
);

    localparam int unsigned GW = 3;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        LOAD,
        RND_A,
        RND_B,
        ANSWER,
        DONE
    } state_t;

    state_t        state;
    logic [GW-1:0] gap_cnt;
    logic          in_msg;
    logic          ready_q;
    logic          accept_c;
    logic          gap_end_c;

    // ready_q is only ever high in IDLE, so it doubles as the IDLE qualifier
    assign accept_c      = blk.blk_valid & ready_q & ~abort;
    assign gap_end_c     = (gap_cnt == GW'(GAP));
    assign blk.blk_ready = ready_q;

    // Sequencer FSM; every strobe is a one-cycle pulse issued on state entry
    always_ff @(posedge clk or posedge rst1) begin
        if (rst1) begin
            state    <= IDLE;
            gap_cnt  <= '0;
            in_msg   <= 1'b0;
            ready_q  <= 1'b1;
            sample_o <= 1'b0;
            ksp_o    <= 1'b0;
            kclk_o   <= 1'b0;
            answer_o <= 1'b0;
            rst2_o   <= 1'b1;
            finish_o <= 1'b0;
            sel_o    <= 1'b0;
            clr_o    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rnd      <= '0;
            blk_cnt  <= '0;
        end else begin
            sample_o <= 1'b0;
            ksp_o    <= 1'b0;
            kclk_o   <= 1'b0;
            answer_o <= 1'b0;
            clr_o    <= 1'b0;
            done     <= 1'b0;

            if (abort) begin
                // Drop the message; the clear pulse scrubs the sponge output
                state    <= IDLE;
                gap_cnt  <= '0;
                in_msg   <= 1'b0;
                ready_q  <= 1'b1;
                rst2_o   <= 1'b1;
                finish_o <= 1'b0;
                clr_o    <= 1'b1;
                busy     <= 1'b0;
                rnd      <= '0;
                blk_cnt  <= '0;
            end else if (state == IDLE) begin
                if (accept_c) begin
                    state    <= SAMPLE;
                    gap_cnt  <= '0;
                    ready_q  <= 1'b0;
                    busy     <= 1'b1;
                    sample_o <= 1'b1;
                    finish_o <= blk.blk_last;
                    if (!in_msg) begin
                        in_msg  <= 1'b1;
                        sel_o   <= blk.blk_mode;
                        blk_cnt <= '0;
                        clr_o   <= 1'b1;
                    end
                end
            end else if (!gap_end_c) begin
                gap_cnt <= gap_cnt + GW'(1);
            end else begin
                gap_cnt <= '0;
                case (state)
                    SAMPLE: begin
                        state  <= LOAD;
                        ksp_o  <= 1'b1;
                        rst2_o <= 1'b1;
                        rnd    <= '0;
                    end
                    LOAD: begin
                        state  <= RND_A;
                        kclk_o <= 1'b1;
                        rst2_o <= 1'b0;
                    end
                    RND_A: begin
                        state <= RND_B;
                        ksp_o <= 1'b1;
                    end
                    RND_B: begin
                        if (rnd == 5'(NR - 1)) begin
                            state    <= ANSWER;
                            answer_o <= 1'b1;
                        end else begin
                            state  <= RND_A;
                            kclk_o <= 1'b1;
                            rnd    <= rnd + 5'd1;
                        end
                    end
                    ANSWER: begin
                        if (blk_cnt != {CNT_W{1'b1}}) begin
                            blk_cnt <= blk_cnt + CNT_W'(1);
                        end
                        if (finish_o) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            ready_q <= 1'b1;
                            rst2_o  <= 1'b1;
                            busy    <= in_msg;
                        end
                    end
                    DONE: begin
                        state    <= IDLE;
                        ready_q  <= 1'b1;
                        rst2_o   <= 1'b1;
                        in_msg   <= 1'b0;
                        finish_o <= 1'b0;
                        rnd      <= '0;
                        busy     <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        rst2_o  <= 1'b1;
                        busy    <= in_msg;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sha3_seq_ctrl.sv
// Bench for sha3_seq_ctrl: GAP=0 and GAP=1 instances against a cycle-offset
// model derived from the strobe timing formulas.
module tb_sha3_seq_ctrl;

    localparam int NR = 24;

    logic clk = 1'b0;
    logic rst1;
    logic drv_valid, drv_last, drv_mode, abort;
    logic csel;

    always #5 clk = ~clk;

    sha3_seq_ctrl_if if0 ();
    sha3_seq_ctrl_if if1 ();

    assign if0.blk_valid = drv_valid & ~csel;
    assign if0.blk_last  = drv_last;
    assign if0.blk_mode  = drv_mode;
    assign if1.blk_valid = drv_valid & csel;
    assign if1.blk_last  = drv_last;
    assign if1.blk_mode  = drv_mode;

    logic       w_sample [2];
    logic       w_ksp    [2];
    logic       w_kclk   [2];
    logic       w_answer [2];
    logic       w_rst2   [2];
    logic       w_finish [2];
    logic       w_sel    [2];
    logic       w_clr    [2];
    logic       w_busy   [2];
    logic       w_done   [2];
    logic [4:0] w_rnd    [2];
    logic [7:0] w_cnt    [2];

    sha3_seq_ctrl #(.NR(NR), .GAP(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst1(rst1), .blk(if0.slave), .abort(abort),
        .sample_o(w_sample[0]), .ksp_o(w_ksp[0]), .kclk_o(w_kclk[0]),
        .answer_o(w_answer[0]), .rst2_o(w_rst2[0]), .finish_o(w_finish[0]),
        .sel_o(w_sel[0]), .clr_o(w_clr[0]), .busy(w_busy[0]), .done(w_done[0]),
        .rnd(w_rnd[0]), .blk_cnt(w_cnt[0])
    );

    sha3_seq_ctrl #(.NR(NR), .GAP(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst1(rst1), .blk(if1.slave), .abort(1'b0),
        .sample_o(w_sample[1]), .ksp_o(w_ksp[1]), .kclk_o(w_kclk[1]),
        .answer_o(w_answer[1]), .rst2_o(w_rst2[1]), .finish_o(w_finish[1]),
        .sel_o(w_sel[1]), .clr_o(w_clr[1]), .busy(w_busy[1]), .done(w_done[1]),
        .rnd(w_rnd[1]), .blk_cnt(w_cnt[1])
    );

    logic       o_sample, o_ksp, o_kclk, o_answer, o_rst2, o_finish;
    logic       o_sel, o_clr, o_busy, o_done, o_ready;
    logic [4:0] o_rnd;
    logic [7:0] o_cnt;
    logic [23:0] o_vec;

    assign o_sample = w_sample[csel];
    assign o_ksp    = w_ksp[csel];
    assign o_kclk   = w_kclk[csel];
    assign o_answer = w_answer[csel];
    assign o_rst2   = w_rst2[csel];
    assign o_finish = w_finish[csel];
    assign o_sel    = w_sel[csel];
    assign o_clr    = w_clr[csel];
    assign o_busy   = w_busy[csel];
    assign o_done   = w_done[csel];
    assign o_rnd    = w_rnd[csel];
    assign o_cnt    = w_cnt[csel];
    assign o_ready  = csel ? if1.blk_ready : if0.blk_ready;
    assign o_vec    = {o_sample, o_ksp, o_kclk, o_answer, o_rst2, o_finish, o_sel,
                       o_clr, o_busy, o_done, o_ready, o_rnd, o_cnt};

    // sample ksp kclk answer rst2 finish sel clr busy done ready rnd cnt
    localparam logic [23:0] RST_VEC = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                       1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 8'd0};

    int checks = 0;
    int errors = 0;

    // message-level model
    bit m_in_msg = 1'b0;
    bit m_sel    = 1'b0;
    int m_cnt    = 0;
    int last_wait;

    // expected strobe at cycle offset j after accept: 0 none, 1 sample, 2 ksp, 3 kclk, 4 answer, 5 done
    function automatic int exp_code(input int j, input int gap, input bit last);
        int p, k;
        p = 1 + gap;
        if (j < 1 || ((j - 1) % p) != 0) return 0;
        k = (j - 1) / p;
        if (k == 0) return 1;
        if (k == 1) return 2;
        if (k <= 2 * NR + 1) return (k % 2 == 0) ? 3 : 2;
        if (k == 2 * NR + 2) return 4;
        if (k == 2 * NR + 3 && last) return 5;
        return 0;
    endfunction

    function automatic int obs_code();
        int n;
        n = int'(o_sample) + int'(o_ksp) + int'(o_kclk) + int'(o_answer) + int'(o_done);
        if (n > 1) return 9;
        if (o_sample) return 1;
        if (o_ksp)    return 2;
        if (o_kclk)   return 3;
        if (o_answer) return 4;
        if (o_done)   return 5;
        return 0;
    endfunction

    // Present one block, wait for accept, then follow it back to IDLE
    task automatic run_block(input bit last, input bit mode);
        int  gap, p, kend, idle_j, k, waited;
        bit  first;
        int  bad_strb, bad_rst2, bad_ctl, bad_hs, bad_rnd, bad_sel;
        int  got_strb, got_rnd;
        gap = csel ? 1 : 0;
        p = 1 + gap;
        drv_valid = 1'b1; drv_last = last; drv_mode = mode;
        waited = 0;
        while (o_ready !== 1'b1 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        last_wait = waited;
        checks++;
        if (waited >= 300) begin
            errors++;
            $display("FAIL accept_timeout: blk_ready=%b after %0d cycles, required 1", o_ready, waited);
            drv_valid = 1'b0;
            return;
        end
        @(posedge clk);
        first = !m_in_msg;
        if (first) begin
            m_sel = mode; m_cnt = 0; m_in_msg = 1'b1;
        end
        kend = last ? 2 * NR + 3 : 2 * NR + 2;
        idle_j = 1 + (kend + 1) * p;
        bad_strb = 0; bad_rst2 = 0; bad_ctl = 0; bad_hs = 0; bad_rnd = 0; bad_sel = 0;
        got_strb = 0; got_rnd = 0;
        for (int j = 1; j <= idle_j; j++) begin
            @(negedge clk);
            if (j == 1) drv_valid = 1'b0;
            k = (j - 1) / p;
            if (bad_strb == 0 && obs_code() != exp_code(j, gap, last)) begin
                bad_strb = j; got_strb = obs_code();
            end
            if (bad_rst2 == 0 && o_rst2 !== ((k <= 1) || (j >= idle_j))) bad_rst2 = j;
            if (bad_ctl == 0 && (o_clr !== (first && j == 1) ||
                                 o_finish !== (last && j < idle_j))) bad_ctl = j;
            if (bad_hs == 0 && (o_ready !== (j >= idle_j) ||
                                o_busy !== ((j < idle_j) || !last))) bad_hs = j;
            if (bad_rnd == 0 && exp_code(j, gap, last) == 3 && int'(o_rnd) != (k - 2) / 2) begin
                bad_rnd = j; got_rnd = int'(o_rnd);
            end
            if (bad_sel == 0 && o_sel !== m_sel) bad_sel = j;
        end
        if (m_cnt != 255) m_cnt++;
        if (last) m_in_msg = 1'b0;

        checks++;
        if (bad_strb != 0) begin
            errors++;
            $display("FAIL strobe_trace: cycle T+%0d code %0d, required %0d", bad_strb, got_strb,
                     exp_code(bad_strb, gap, last));
        end
        checks++;
        if (bad_rst2 != 0) begin
            errors++;
            $display("FAIL rst2_trace: wrong rst2_o at cycle T+%0d", bad_rst2);
        end
        checks++;
        if (bad_ctl != 0) begin
            errors++;
            $display("FAIL clr_finish_trace: wrong clr_o/finish_o at cycle T+%0d (first=%0b last=%0b)",
                     bad_ctl, first, last);
        end
        checks++;
        if (bad_hs != 0) begin
            errors++;
            $display("FAIL ready_busy_trace: wrong blk_ready/busy at cycle T+%0d (idle at T+%0d)",
                     bad_hs, idle_j);
        end
        checks++;
        if (bad_rnd != 0) begin
            errors++;
            $display("FAIL rnd_trace: rnd=%0d at cycle T+%0d, required %0d", got_rnd, bad_rnd,
                     ((bad_rnd - 1) / p - 2) / 2);
        end
        checks++;
        if (bad_sel != 0) begin
            errors++;
            $display("FAIL sel_trace: sel_o wrong at cycle T+%0d, required %0b", bad_sel, m_sel);
        end
        checks++;
        if (int'(o_cnt) != m_cnt) begin
            errors++;
            $display("FAIL blk_cnt: got %0d, required %0d", o_cnt, m_cnt);
        end
    endtask

    task automatic test_reset();
        rst1 = 1'b1; drv_valid = 1'b0; drv_last = 1'b0; drv_mode = 1'b0; abort = 1'b0; csel = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (o_vec !== RST_VEC) begin
            errors++;
            $display("FAIL reset_dut0: outputs %h, required %h", o_vec, RST_VEC);
        end
        csel = 1'b1;
        #1;
        checks++;
        if (o_vec !== RST_VEC) begin
            errors++;
            $display("FAIL reset_dut1: outputs %h, required %h", o_vec, RST_VEC);
        end
        csel = 1'b0;
        @(negedge clk);
        rst1 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (o_vec !== RST_VEC) begin
            errors++;
            $display("FAIL idle_after_reset: outputs %h, required %h", o_vec, RST_VEC);
        end
    endtask

    task automatic test_single_gap0();
        csel = 1'b0;
        run_block(1'b1, 1'b1);
    endtask

    task automatic test_single_gap1();
        csel = 1'b1;
        run_block(1'b1, 1'b1);
        csel = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_two_block();
        csel = 1'b0;
        run_block(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (o_busy !== 1'b1 || o_done !== 1'b0 || o_sel !== 1'b0) begin
            errors++;
            $display("FAIL between_blocks: busy=%b done=%b sel=%b, required 1 0 0", o_busy, o_done, o_sel);
        end
        run_block(1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        csel = 1'b0;
        run_block(1'b0, 1'b1);
        run_block(1'b0, 1'b0);
        checks++;
        if (last_wait != 0) begin
            errors++;
            $display("FAIL back_to_back_accept: waited %0d cycles, required 0", last_wait);
        end
        run_block(1'b1, 1'b0);
        checks++;
        if (last_wait != 0) begin
            errors++;
            $display("FAIL back_to_back_last: waited %0d cycles, required 0", last_wait);
        end
    endtask

    task automatic test_random();
        int len;
        csel = 1'b0;
        for (int m = 0; m < 6; m++) begin
            len = int'($urandom_range(1, 3));
            for (int b = 0; b < len; b++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                run_block(b == len - 1, 1'($urandom));
            end
        end
    endtask

    task automatic test_saturate();
        csel = 1'b0;
        for (int b = 0; b < 258; b++) run_block(1'b0, 1'b0);
        run_block(1'b1, 1'b0);
        checks++;
        if (o_cnt !== 8'hff) begin
            errors++;
            $display("FAIL blk_cnt_saturate: got %0d, required 255", o_cnt);
        end
    endtask

    task automatic test_abort_rnd();
        int  n;
        bit  seen;
        csel = 1'b0;
        drv_valid = 1'b1; drv_last = 1'b1; drv_mode = 1'($urandom);
        n = 0;
        while (o_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b0;
        n = 0;
        while (!(o_ksp === 1'b1 && o_rnd == 5'd10 && o_rst2 === 1'b0) && n < 200) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL abort_reach_rnd10: RND_B with rnd=10 not seen within 200 cycles");
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        m_in_msg = 1'b0; m_cnt = 0;
        checks++;
        if (o_clr !== 1'b1 || o_rnd !== 5'd0 || o_ready !== 1'b1 || o_busy !== 1'b0 ||
            o_rst2 !== 1'b1 || o_finish !== 1'b0 || o_cnt !== 8'd0 || obs_code() != 0) begin
            errors++;
            $display("FAIL abort_state: clr=%b rnd=%0d ready=%b busy=%b rst2=%b finish=%b cnt=%0d strobe=%0d, required 1 0 1 0 1 0 0 0",
                     o_clr, o_rnd, o_ready, o_busy, o_rst2, o_finish, o_cnt, obs_code());
        end
        seen = 1'b0;
        for (int j = 0; j < 80; j++) begin
            @(negedge clk);
            if (obs_code() != 0 || o_clr !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_quiet: strobe, clr or done after abort, required none");
        end
    endtask

    task automatic test_abort_with_valid();
        bit seen;
        csel = 1'b0;
        drv_valid = 1'b1; drv_last = 1'b1; drv_mode = 1'b1; abort = 1'b1;
        @(negedge clk);
        drv_valid = 1'b0; abort = 1'b0;
        checks++;
        if (o_sample !== 1'b0 || o_ready !== 1'b1 || o_clr !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_valid_idle: sample=%b ready=%b clr=%b busy=%b, required 0 1 1 0",
                     o_sample, o_ready, o_clr, o_busy);
        end
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (obs_code() != 0 || o_ready !== 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_valid_quiet: activity after rejected block, required none");
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit seen;
        csel = 1'b0;
        drv_valid = 1'b1; drv_last = 1'b1; drv_mode = 1'b1;
        n = 0;
        while (o_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b0;
        n = 0;
        while (!(o_kclk === 1'b1 && o_rnd == 5'd5) && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL reset_mid_reach_rnd5: round 5 not seen within 200 cycles");
        end
        #2 rst1 = 1'b1;
        #1;
        checks++;
        if (o_vec !== RST_VEC) begin
            errors++;
            $display("FAIL reset_mid_async: outputs %h, required %h", o_vec, RST_VEC);
        end
        @(negedge clk);
        rst1 = 1'b0;
        m_in_msg = 1'b0; m_sel = 1'b0; m_cnt = 0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (o_vec !== RST_VEC) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_release_glitch: outputs %h after release, required %h", o_vec, RST_VEC);
        end
        run_block(1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_gap0();
        test_single_gap1();
        test_two_block();
        test_back_to_back();
        test_abort_rnd();
        test_abort_with_valid();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
